// File: rtl/random_pkg.sv
// random_pkg: shared definitions for both ends of the 16-bit LFSR random
// word link. The generator and the checker import this package, so they use
// the same step function and tap set.
//   LFSR_W       word width
//   TAP_*        feedback taps of the per-bit shift
//   lfsr_next16  advances a word by 16 single-bit LFSR steps
//   chk_state_t  checker lock state
package random_pkg;

  localparam int LFSR_W = 16;

  localparam int TAP_A = 15;
  localparam int TAP_B = 14;
  localparam int TAP_C = 12;
  localparam int TAP_D = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One generator word is 16 single-bit steps. The feedback bit enters at
  // the MSB and the word shifts right. This is pure combinational logic.
  function automatic logic [LFSR_W-1:0] lfsr_next16(input logic [LFSR_W-1:0] w);
    logic [LFSR_W-1:0] s;
    s = w;
    for (int i = 0; i < LFSR_W; i++) begin
      s = {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
    end
    return s;
  endfunction

endpackage

// File: rtl/random_check16.sv
// random_check16: receive-side checker for the 16-bit LFSR word stream.
// The checker synchronises to the incoming words by itself. After it locks,
// it predicts each following word, flags mismatches and counts errors.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a stream word this cycle
//   in_data    received word
//   err_clear  synchronous clear of err_count; does not change lock state
//   locked     registered: state is LOCKED
//   err        one-cycle pulse when a word compared in LOCKED mismatched
//   err_count  saturating count of LOCKED mismatches
//   expected   prediction for the next valid word (meaningful in VERIFY/LOCKED)
//   dbg_state  current checker state, for observation
//
// Handshake: the input has no backpressure. A word is consumed on every
// rising edge where in_valid=1. Cycles with in_valid=0 change nothing.
module random_check16
  import random_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [LFSR_W-1:0]   in_data,
  input  logic                err_clear,
  output logic                locked,
  output logic                err,
  output logic [ERR_W-1:0]    err_count,
  output logic [LFSR_W-1:0]   expected,
  output chk_state_t          dbg_state
);

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_t        state_q, state_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic [LFSR_W-1:0] exp_d;
  logic              err_d;
  logic [ERR_W-1:0]  cnt_d;

  logic [LFSR_W-1:0] pred_self;
  logic [LFSR_W-1:0] pred_in;
  logic              hit;
  logic [3:0]        match_inc;
  logic [3:0]        miss_inc;

  assign pred_self = lfsr_next16(expected);
  assign pred_in   = lfsr_next16(in_data);
  assign hit       = (in_data == expected);
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    exp_d   = expected;
    err_d   = 1'b0;
    cnt_d   = err_count;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // All-zero is the LFSR lockup word, so it cannot seed a prediction.
          if (in_data != '0) begin
            exp_d   = pred_in;
            match_d = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            match_d = match_inc;
            exp_d   = pred_self;
            if (match_inc == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else if (in_data != '0) begin
            // Wrong guess while acquiring: reseed from the received word.
            exp_d   = pred_in;
            match_d = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Once locked, the prediction advances by itself. Received data
          // never reseeds it, so a single corrupt word cannot break the
          // phase of the prediction.
          exp_d = pred_self;
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LOSS_C) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // When a clear and an increment fall in the same cycle, the clear wins.
    if (err_clear) begin
      cnt_d = '0;
    end else if (err_d && (err_count != ERR_MAX)) begin
      cnt_d = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      expected  <= '0;
      err       <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      expected  <= exp_d;
      err       <= err_d;
      err_count <= cnt_d;
      locked    <= (state_d == LOCKED);
    end
  end

endmodule

// File: doc/random_check16.md
Name: random_check16

Overview:
- Receive-side checker for the 16-bit LFSR random word stream used by the POMDP sampling path.
- Self-synchronises to an incoming stream of 16-bit words from the generator, which advances 16 LFSR steps per word.
- Once locked, predicts every following word, flags mismatches and counts errors.
- Sits at the consumer end of a generator link, or on a loopback/debug tap, so stream integrity can be checked in-system.

Parameters:
- LOCK_CNT, 4: consecutive correct predictions needed to go from VERIFY to LOCKED (range 1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force a return to HUNT (range 1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data carries a stream word this cycle.
- in_data  in  16  received word.
- err_clear  in  1  synchronous clear of err_count. Lock state is unaffected.
- locked  out  1  state is LOCKED.
- err  out  1  one-cycle pulse: a word compared in LOCKED did not match.
- err_count  out  ERR_W  saturating count of LOCKED mismatches.
- expected  out  16  prediction for the next valid word. Meaningful in VERIFY and LOCKED.

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT, locked=0, err=0, err_count=0, expected=16'h0000.
  - Internal match and miss counters = 0.
  - Reset mid-operation discards lock immediately.
- Step function nxt(w): apply 16 times, in order, w = {w[15]^w[14]^w[12]^w[4], w[15:1]}. Purely combinational; bit-exact with the generator.
- Cycles with in_valid=0: no state change, no err, expected holds.
- All registered outputs update on the clock edge that samples the valid word. err is high in the following cycle only.
- HUNT:
  - Valid word w != 0: expected<=nxt(w), match_cnt<=0, go to VERIFY.
  - w == 0: ignored, stay in HUNT. All-zero is the lockup state.
- VERIFY, on a valid word w:
  - w==expected: match_cnt++, expected<=nxt(expected).
  - If match_cnt+1==LOCK_CNT: go to LOCKED, miss_cnt<=0.
  - w!=expected and w!=0: reseed, expected<=nxt(w), match_cnt<=0, stay in VERIFY.
  - w!=expected and w==0: go to HUNT.
  - err is never asserted in VERIFY.
- LOCKED, on a valid word w:
  - expected<=nxt(expected) always; never reseeded from in_data while LOCKED.
  - Match: miss_cnt<=0.
  - Mismatch: err pulse, err_count+1 (saturates at all-ones), miss_cnt++.
  - If miss_cnt+1==LOSS_CNT: go to HUNT, locked drops in the next cycle.
  - The word that causes loss is counted as an error but not used to reseed.
- err_clear:
  - err_count<=0.
  - If err_clear and an increment occur in the same cycle: clear wins, result 0.
- locked = (state==LOCKED), registered.

Decomposition:
- Package random_pkg holds:
  - LFSR_W=16.
  - Tap constants {15,14,12,4}.
  - Function lfsr_next16(), implementing nxt().
  - Enum chk_state_t {HUNT, VERIFY, LOCKED}.
- The generator and checker both import random_pkg so that both ends of the link share one step function.
- No sub-module is needed. Single always_ff for state and counters, always_comb for next-state.

Test Plan:
- Reset: hold rst_n=0 -> locked=0, err=0, err_count=0, expected=0000. Then drive in_valid=0 for 10 cycles -> all outputs unchanged.
- Step function: valid 16'h8000 in HUNT -> expected=16'h4AC5 next cycle. Valid 16'h0001 in HUNT -> expected=16'h0000, which is a legal single value.
- Acquire lock: drive 16'h8000, then 16'h4AC5, then 3 further words from a bench model of lfsr_next16 -> locked rises after the 5th valid word (LOCK_CNT=4), with no err. Inserting in_valid=0 gaps gives the same result.
- Single error: while locked, replace one word with word^16'h0001 -> one err pulse, err_count=1, locked stays 1. The following correct words match, proving expected was not reseeded.
- Loss of lock: 3 consecutive corrupted words while locked -> 3 err pulses, err_count=3, locked=0 after the 3rd. A new clean stream then relocks after 1+LOCK_CNT words.
- Counter and clear, with ERR_W=2:
  - 5 mismatches, interleaved with matches so lock is kept -> err_count saturates at 3.
  - err_clear in the same cycle as a mismatch -> err_count=0.
  - Zero words in HUNT are ignored.
